// File: rtl/ram_loader_pkg.sv
// Shared constants and state encoding for the boot-time RAM loader.
package ram_loader_pkg;

    // Checksum width; all sums wrap modulo 2^SUM_W.
    localparam int SUM_W = 16;

    // Default frame start marker.
    localparam logic [7:0] DEF_SYNC_BYTE = 8'h55;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_H,
        ST_LEN_L,
        ST_DATA_H,
        ST_DATA_L,
        ST_SUM_H,
        ST_SUM_L,
        ST_VERIFY,
        ST_FINISH
    } state_e;

endpackage

// File: rtl/ram_loader_word_assembler.sv
// Pairs a high-byte strobe and a following low-byte strobe into one 16-bit
// word, presented with a single-cycle valid the cycle after the low byte.
module word_assembler (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_hi_stb,
    input  logic        i_lo_stb,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [15:0] o_word
);

    logic [7:0]  hi_q;
    logic [15:0] word_q;
    logic        vld_q;

    // Latch the high byte, then form the word and flag it for one cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hi_q   <= '0;
            word_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= i_lo_stb;
            if (i_hi_stb) hi_q <= i_byte;
            if (i_lo_stb) word_q <= {hi_q, i_byte};
        end
    end

    assign o_word_valid = vld_q;
    assign o_word       = word_q;

endmodule

// File: rtl/ram_loader.sv
// Boot loader: parses SYNC/LEN/DATA/SUM frames, writes words into RAM,
// then reads them all back and checks the readback sum before signalling.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte,
    output logic                  o_ram_load,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [15:0]           o_ram_data,
    input  logic [15:0]           i_ram_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    // Word counter is one bit wider than the address so a full-depth load fits.
    localparam int CW = ADDR_WIDTH + 1;

    state_e                state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [CW-1:0]         len_q, len_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         vcnt_q, vcnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            sum_hi_q, sum_hi_d;
    logic [SUM_W-1:0]      rx_sum_q, rx_sum_d;
    logic [SUM_W-1:0]      rcv_sum_q, rcv_sum_d;
    logic [SUM_W-1:0]      rb_sum_q, rb_sum_d;
    logic                  err_q, err_d;

    logic                  hi_stb, lo_stb;
    logic                  word_valid;
    logic [15:0]           word;
    logic                  done;
    logic                  fin_fail;
    logic [15:0]           n;

    word_assembler u_asm (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_hi_stb     (hi_stb),
        .i_lo_stb     (lo_stb),
        .i_byte       (i_byte),
        .o_word_valid (word_valid),
        .o_word       (word)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Datapath registers: lengths, counters, sums, address and sticky error.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            len_hi_q  <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            vcnt_q    <= '0;
            addr_q    <= '0;
            sum_hi_q  <= '0;
            rx_sum_q  <= '0;
            rcv_sum_q <= '0;
            rb_sum_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            len_hi_q  <= len_hi_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            vcnt_q    <= vcnt_d;
            addr_q    <= addr_d;
            sum_hi_q  <= sum_hi_d;
            rx_sum_q  <= rx_sum_d;
            rcv_sum_q <= rcv_sum_d;
            rb_sum_q  <= rb_sum_d;
            err_q     <= err_d;
        end
    end

    // Frame parser, verify sequencer and next-state logic.
    always_comb begin
        state_d   = state_q;
        len_hi_d  = len_hi_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        vcnt_d    = vcnt_q;
        addr_d    = addr_q;
        sum_hi_d  = sum_hi_q;
        rcv_sum_d = rcv_sum_q;
        rb_sum_d  = rb_sum_q;
        err_d     = err_q;
        hi_stb    = 1'b0;
        lo_stb    = 1'b0;
        done      = 1'b0;
        fin_fail  = 1'b0;
        n         = {len_hi_q, i_byte};
        // The receive sum follows the assembled words; the last word lands
        // in SUM_H, ahead of the earliest possible SUM_L compare.
        rx_sum_d  = word_valid ? rx_sum_q + word : rx_sum_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_byte_valid && i_byte == SYNC_BYTE) begin
                    state_d  = ST_LEN_H;
                    err_d    = 1'b0;
                    rx_sum_d = '0;
                    rb_sum_d = '0;
                    cnt_d    = '0;
                end
            end
            ST_LEN_H: begin
                if (i_byte_valid) begin
                    len_hi_d = i_byte;
                    state_d  = ST_LEN_L;
                end
            end
            ST_LEN_L: begin
                if (i_byte_valid) begin
                    if (n == 16'd0 || 17'(n) > (17'd1 << ADDR_WIDTH)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        len_d   = n[CW-1:0];
                        cnt_d   = '0;
                        addr_d  = '0;
                        state_d = ST_DATA_H;
                    end
                end
            end
            ST_DATA_H: begin
                hi_stb = i_byte_valid;
                if (i_byte_valid) state_d = ST_DATA_L;
            end
            ST_DATA_L: begin
                lo_stb = i_byte_valid;
                if (i_byte_valid) begin
                    // Address registers alongside the assembled word so both
                    // appear together on the write cycle.
                    addr_d  = cnt_q[ADDR_WIDTH-1:0];
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_q + CW'(1) == len_q) ? ST_SUM_H : ST_DATA_H;
                end
            end
            ST_SUM_H: begin
                if (i_byte_valid) begin
                    sum_hi_d = i_byte;
                    state_d  = ST_SUM_L;
                end
            end
            ST_SUM_L: begin
                if (i_byte_valid) begin
                    if ({sum_hi_q, i_byte} != rx_sum_q) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        rcv_sum_d = {sum_hi_q, i_byte};
                        addr_d    = '0;
                        vcnt_d    = '0;
                        rb_sum_d  = '0;
                        state_d   = ST_VERIFY;
                    end
                end
            end
            ST_VERIFY: begin
                // Cycle v presents address v (v < N) and accumulates the
                // word read in cycle v-1 (v >= 1); cycle N is compare-only.
                vcnt_d = vcnt_q + CW'(1);
                if (vcnt_q != '0) rb_sum_d = rb_sum_q + i_ram_data;
                if (vcnt_q + CW'(1) < len_q) addr_d = addr_q + ADDR_WIDTH'(1);
                if (vcnt_q == len_q) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                if (rb_sum_q == rcv_sum_q) begin
                    done = 1'b1;
                end else begin
                    fin_fail = 1'b1;
                    err_d    = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_ram_load = word_valid;
    assign o_ram_data = word;
    assign o_ram_addr = addr_q;
    assign o_busy     = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign o_done     = done;
    assign o_error    = err_q | fin_fail;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: table of frames driven byte by byte, write
// scoreboard, behavioural 16-bit synchronous RAM with read corruption.
module tb_ram_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bv  = 1'b0;
    logic [7:0]    bt  = 8'h00;
    logic          ld;
    logic [AW-1:0] addr;
    logic [15:0]   wd;
    logic [15:0]   rd;
    logic          busy, done, err;

    always #5 clk = ~clk;

    ram_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'h55)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_byte_valid (bv),
        .i_byte       (bt),
        .o_ram_load   (ld),
        .o_ram_addr   (addr),
        .o_ram_data   (wd),
        .i_ram_data   (rd),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (err)
    );

    // Target memory: registered read, optional corruption of address 1.
    logic [15:0]   mem [DEPTH];
    logic [15:0]   rdata_q = '0;
    logic [AW-1:0] raddr_q = '0;
    bit            corrupt = 1'b0;
    always @(posedge clk) begin
        if (ld) mem[addr] <= wd;
        rdata_q <= mem[addr];
        raddr_q <= addr;
    end
    assign rd = (corrupt && raddr_q == AW'(1)) ? (rdata_q ^ 16'h00F0) : rdata_q;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [15:0]   d;
        logic [31:0]   c;
    } wr_t;

    typedef struct {
        string       name;
        logic [7:0]  b[48];
        int          nb;
        int          ds;
        int          nw;
        logic [15:0] w[DEPTH];
        int          gap;
        bit          corrupt;
        bit          exp_done;
        bit          exp_err;
    } frame_t;

    wr_t    sb[$];
    frame_t ft[8];
    int     checks   = 0;
    int     errors   = 0;
    int     cyc      = 0;
    int     done_cnt = 0;
    int     done_cyc = 0;
    int     wr_cnt   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every RAM write must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (ld) begin
                wr_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0h data=%0h cyc=%0d", addr, wd, cyc);
                end else begin
                    e = sb.pop_front();
                    if (addr !== e.a || wd !== e.d || cyc !== int'(e.c)) begin
                        errors++;
                        $display("FAIL write actual addr=%0h data=%0h cyc=%0d expected addr=%0h data=%0h cyc=%0d",
                                 addr, wd, cyc, e.a, e.d, e.c);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Build a frame: ng garbage bytes, sync, length, words (pre-filled in w), sum.
    task automatic mk(input int k, input string nm, input int len, input int ng, input int gap,
                      input bit corr, input bit bad_sum, input bit ed, input bit ee);
        int          p;
        logic [15:0] s;
        logic [15:0] l;
        p = 0;
        s = '0;
        l = 16'(len);
        ft[k].name = nm;
        for (int i = 0; i < ng; i++) begin
            ft[k].b[p] = (i % 2 == 0) ? 8'h00 : 8'hFF;
            p++;
        end
        ft[k].b[p] = 8'h55;  p++;
        ft[k].b[p] = l[15:8]; p++;
        ft[k].b[p] = l[7:0];  p++;
        ft[k].ds = p;
        ft[k].nw = 0;
        if (len >= 1 && len <= DEPTH) begin
            ft[k].nw = len;
            for (int i = 0; i < len; i++) begin
                ft[k].b[p] = ft[k].w[i][15:8]; p++;
                ft[k].b[p] = ft[k].w[i][7:0];  p++;
                s = s + ft[k].w[i];
            end
            if (bad_sum) s = s + 16'd1;
            ft[k].b[p] = s[15:8]; p++;
            ft[k].b[p] = s[7:0];  p++;
        end
        ft[k].nb       = p;
        ft[k].gap      = gap;
        ft[k].corrupt  = corr;
        ft[k].exp_done = ed;
        ft[k].exp_err  = ee;
    endtask

    // Drive one table frame, then check the outcome.
    task automatic run_frame(input int k);
        int sl_cyc;
        int t;
        int bad;
        int o;
        done_cnt = 0;
        wr_cnt   = 0;
        sl_cyc   = 0;
        corrupt  = ft[k].corrupt;
        for (int i = 0; i < ft[k].nb; i++) begin
            @(posedge clk); #1;
            if (i == ft[k].ds - 2) begin
                chk({ft[k].name, "_busy_after_sync"}, 32'(busy), 32'd1);
                chk({ft[k].name, "_err_clr_at_sync"}, 32'(err), 32'd0);
            end
            bv = 1'b1;
            bt = ft[k].b[i];
            o  = i - ft[k].ds;
            if (o >= 0 && o < 2 * ft[k].nw && (o % 2) == 1)
                sb.push_back('{a: AW'(o / 2), d: ft[k].w[o / 2], c: 32'(cyc + 1)});
            sl_cyc = cyc;
            if (ft[k].gap != 0) begin
                @(posedge clk); #1;
                bv = 1'b0;
            end
        end
        @(posedge clk); #1;
        bv = 1'b0;
        t = 0;
        while (busy && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk({ft[k].name, "_busy_timeout"}, 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk({ft[k].name, "_done_pulses"}, 32'(done_cnt), 32'(ft[k].exp_done));
        chk({ft[k].name, "_error"}, 32'(err), 32'(ft[k].exp_err));
        chk({ft[k].name, "_writes"}, 32'(wr_cnt), 32'(ft[k].nw));
        chk({ft[k].name, "_sb_empty"}, 32'(sb.size()), 32'd0);
        if (ft[k].exp_done)
            chk({ft[k].name, "_done_cycle"}, 32'(done_cyc), 32'(sl_cyc + ft[k].nw + 2));
        bad = 0;
        for (int i = 0; i < ft[k].nw; i++)
            if (mem[i] !== ft[k].w[i]) bad++;
        chk({ft[k].name, "_ram_contents_bad"}, 32'(bad), 32'd0);
        corrupt = 1'b0;
        sb.delete();
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_load"}, 32'(ld), 32'd0);
        chk({nm, "_addr"}, 32'(addr), 32'd0);
        chk({nm, "_data"}, 32'(wd), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_error"}, 32'(err), 32'd0);
    endtask

    initial begin
        logic [7:0] partial [8];

        // Frame table.
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < DEPTH; i++) ft[k].w[i] = '0;
        for (int k = 0; k < 8; k++) begin
            ft[k].w[0] = 16'h1234;
            ft[k].w[1] = 16'hABCD;
            ft[k].w[2] = 16'h0001;
        end
        for (int i = 0; i < DEPTH; i++) ft[5].w[i] = 16'(i * 16'h1111 + 16'h0F0F);
        // SUM of 1234+ABCD+0001 = BE02; bad-sum frame sends BE03.
        mk(0, "basic",     3, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        mk(1, "bad_sum",   3, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        mk(2, "recover",   3, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        mk(3, "len0",      0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        mk(4, "len17",    17, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        mk(5, "len16",    16, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        mk(6, "garbage",   3, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        mk(7, "vfy_bad",   3, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < DEPTH; i++) mem[i] = 16'hDEAD;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        for (int k = 0; k < 8; k++) run_frame(k);

        // Reset while the low byte of word 2 is being strobed.
        partial[0] = 8'h55; partial[1] = 8'h00; partial[2] = 8'h03; partial[3] = 8'h12;
        partial[4] = 8'h34; partial[5] = 8'hAB; partial[6] = 8'hCD; partial[7] = 8'h56;
        wr_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            bv = 1'b1;
            bt = partial[i];
            if (i == 4) sb.push_back('{a: AW'(0), d: 16'h1234, c: 32'(cyc + 1)});
            if (i == 6) sb.push_back('{a: AW'(1), d: 16'hABCD, c: 32'(cyc + 1)});
        end
        @(posedge clk); #1;
        bt  = 8'h78;
        rst = 1'b1;
        @(posedge clk); #1;
        bv  = 1'b0;
        rst = 1'b0;
        chk_reset_outputs("midreset");
        chk("midreset_writes", 32'(wr_cnt), 32'd2);
        chk("midreset_sb_empty", 32'(sb.size()), 32'd0);
        sb.delete();
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'hDEAD;
        run_frame(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
